tdc_ctrl: RTL and testbench

- Measurement sequencer for the TDC delay line: launches an edge into the line, captures the tap vector one clock later, and converts the thermometer code to a binary tap count.
- Accumulates 2^AVG_LOG2 back-to-back samples, checks the line has cleared between launches, and returns the summed result over a valid/ready handshake.
- Sits between the delay line (drives its `in`, reads its `dl_out`) and the readout/scan logic.

---
 rtl/tdc_ctrl.sv | 110 +++++++++++
 tb/tb_tdc_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/tdc_ctrl.sv
// TDC measurement sequencer: launches an edge into the delay line, captures the taps,
// popcounts them and accumulates 2^AVG_LOG2 samples before a valid/ready handoff.
module tdc_ctrl #(
  parameter int N             = 64,
  parameter int AVG_LOG2      = 2,
  parameter int SETTLE_CYCLES = 2,
  localparam int CW           = $clog2(N + 1),
  localparam int RW           = CW + AVG_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          dl_in,
  input  logic [N-1:0]  dl_taps,
  output logic [RW-1:0] result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          ovf,
  output logic          clr_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CLEAR  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SCW = AVG_LOG2 + 1;

  logic [2:0]     state, next_state;
  logic [N-1:0]   tap_q;
  logic [SW-1:0]  settle_cnt;
  logic [SCW-1:0] sample_cnt;
  logic [CW-1:0]  ones;
  logic           settle_last, last_sample;

  assign settle_last = (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign last_sample = (sample_cnt == SCW'((1 << AVG_LOG2) - 1));

  // Ones-count rather than first-zero search keeps bubbles from causing large errors
  always_comb begin
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(tap_q[i]);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_LAUNCH;
      S_LAUNCH: next_state = S_SAMPLE;
      S_SAMPLE: next_state = S_CLEAR;
      S_CLEAR:  if (settle_last) next_state = last_sample ? S_DONE : S_LAUNCH;
      S_DONE:   if (result_valid && result_ready) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Taps are sampled raw every edge; metastable taps only perturb the count by one each
  always_ff @(posedge clk) begin
    tap_q <= dl_taps;
  end

  // Outputs are registered from next_state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dl_in        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      ovf          <= 1'b0;
      clr_err      <= 1'b0;
      sample_cnt   <= '0;
      settle_cnt   <= '0;
    end else begin
      state        <= next_state;
      dl_in        <= (next_state == S_LAUNCH);
      busy         <= (next_state != S_IDLE);
      result_valid <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            result     <= '0;
            sample_cnt <= '0;
            ovf        <= 1'b0;
            clr_err    <= 1'b0;
          end
        end
        S_SAMPLE: begin
          result     <= result + RW'(ones);
          settle_cnt <= '0;
          if (&tap_q) ovf <= 1'b1;
        end
        S_CLEAR: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_last) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (|tap_q) clr_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_ctrl.sv
// Directed testbench for tdc_ctrl with a behavioural delay-line model driving dl_taps.
module tb_tdc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        dl_in;
  logic [63:0] dl_taps;
  logic [8:0]  result;
  logic        result_valid;
  logic        result_ready;
  logic        ovf;
  logic        clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Delay line model: the launch pattern appears while dl_in is high, else the line reads clear
  logic [63:0] pat [4];
  int          launch_cnt = 0;
  int          base = 0;
  int          idx;
  logic        dirty = 1'b0;

  tdc_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .dl_in(dl_in),
    .dl_taps(dl_taps), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .ovf(ovf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dl_in) launch_cnt <= launch_cnt + 1;
  end

  always_comb begin
    idx     = launch_cnt - base;
    dl_taps = 64'h0;
    if (dl_in) dl_taps = pat[idx & 3];
    else if (dirty && idx == 2) dl_taps = 64'h1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_pats(input logic [63:0] p0, p1, p2, p3);
    pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
  endtask

  // Runs one full measurement from start, checking the launch cadence cycle by cycle
  task automatic measure(input string tag, input logic [8:0] exp_res,
                         input logic exp_ovf, input logic exp_clr);
    base  = launch_cnt;
    start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      check_output({tag, " dl_in"}, 64'(dl_in), 64'((k <= 13) && (k % 4 == 1)));
      check_output({tag, " busy"}, 64'(busy), 64'd1);
      check_output({tag, " valid"}, 64'(result_valid), 64'(k == 17));
    end
    check_output({tag, " result"}, 64'(result), 64'(exp_res));
    check_output({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    check_output({tag, " clr_err"}, 64'(clr_err), 64'(exp_clr));
  endtask

  task automatic handshake(input string tag, input logic [8:0] exp_res);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check_output({tag, " hs valid"}, 64'(result_valid), 64'd0);
    check_output({tag, " hs busy"}, 64'(busy), 64'd0);
    check_output({tag, " hs result kept"}, 64'(result), 64'(exp_res));
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b1;
    result_ready = 1'b0;
    set_pats(64'hF_FFFF, 64'hF_FFFF, 64'hF_FFFF, 64'hF_FFFF);

    // Reset held with start asserted: nothing may launch
    for (int k = 0; k < 3; k++) begin
      tick();
      check_output("rst dl_in", 64'(dl_in), 64'd0);
      check_output("rst busy", 64'(busy), 64'd0);
      check_output("rst valid", 64'(result_valid), 64'd0);
      check_output("rst result", 64'(result), 64'd0);
      check_output("rst ovf", 64'(ovf), 64'd0);
      check_output("rst clr_err", 64'(clr_err), 64'd0);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_output("idle busy", 64'(busy), 64'd0);

    // 20 ones per sample, four samples
    measure("basic", 9'd80, 1'b0, 1'b0);
    handshake("basic", 9'd80);

    // Overflow sample plus a bubbled code with six ones
    set_pats(64'hFFFF_FFFF_FFFF_FFFF, 64'h175, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    measure("ovf", 9'd134, 1'b1, 1'b0);
    handshake("ovf", 9'd134);

    // Line fails to clear after the second launch
    set_pats(64'hF_FFFF, 64'hF_FFFF, 64'hF_FFFF, 64'hF_FFFF);
    dirty = 1'b1;
    measure("clr", 9'd80, 1'b0, 1'b1);
    dirty = 1'b0;

    // Backpressure: hold ready low, poke start, result must stay put
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_output("bp valid", 64'(result_valid), 64'd1);
      check_output("bp result", 64'(result), 64'd80);
      check_output("bp busy", 64'(busy), 64'd1);
      check_output("bp clr_err", 64'(clr_err), 64'd1);
    end
    start = 1'b0;
    handshake("bp", 9'd80);
    tick();
    check_output("bp start ignored", 64'(busy), 64'd0);

    // Reset during the third CLEAR aborts the measurement
    base  = launch_cnt;
    start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 1) start = 1'b0;
    end
    check_output("abort pre busy", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("abort dl_in", 64'(dl_in), 64'd0);
    check_output("abort busy", 64'(busy), 64'd0);
    check_output("abort valid", 64'(result_valid), 64'd0);
    check_output("abort result", 64'(result), 64'd0);
    tick();
    check_output("abort stays idle", 64'(busy), 64'd0);

    measure("after abort", 9'd80, 1'b0, 1'b0);
    handshake("after abort", 9'd80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
